ita_timer_slv: RTL
==================

# ita_timer_slv

Responder at the far end of the core's ITA port: it accepts single read/write requests issued by the load/store path (`wr`, `rd`, `addr`, `wdata`, `valid`) and returns `rdata`/`ready` after a programmable number of wait states. Behind the port sits a memory-mapped 64-bit machine timer (mtime/mtimecmp, prescaler, control) that raises a level timer interrupt. It is the first ITA peripheral and the template for later ones.

## Interface
- `BASE_ADDR`, 32'h1000_0000: block base; bits [`PC_SIZE`-1:5] must match for a hit.
- `WAIT_CYCLES`, 1: extra cycles between acceptance and response, legal range 0..7.
- `clk` in 1: core clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ita_i_valid` in 1: request valid; initiator holds it, and all request fields, stable until `ita_o_ready`.
- `ita_i_wr` in 1: write request.
- `ita_i_rd` in 1: read request.
- `ita_i_addr` in `PC_SIZE`: byte address, word aligned (bits [1:0] ignored).
- `ita_i_wdata` in `XLEN`: write data (32 bits).
- `ita_o_rdata` out `XLEN`: read data, valid only while `ita_o_ready`=1, else 0.
- `ita_o_ready` out 1: one-cycle response pulse; completes the request.
- `ita_o_tmr_irq` out 1: timer interrupt, level.

## Operation
- Register map (offset = addr[4:2]):
  - 0x00 MTIME_LO, RW.
  - 0x04 MTIME_HI, RW.
  - 0x08 MTIMECMP_LO, RW.
  - 0x0C MTIMECMP_HI, RW.
  - 0x10 CTRL, RW: bit0 EN, other bits read 0.
  - 0x14 PRESC, RW: bits [15:0] only.
  - 0x18 and 0x1C: unmapped, read 0, write ignored.
  - Base-address miss: read 0, write ignored. Still answered with `ita_o_ready`. No error path.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT when `ita_i_valid`=1 and `WAIT_CYCLES`>0. Load the wait counter with `WAIT_CYCLES`-1.
  - IDLE → RESP when `ita_i_valid`=1 and `WAIT_CYCLES`=0.
  - WAIT: decrement the counter; go to RESP when it reaches 0.
  - RESP → IDLE unconditionally. `ita_o_ready`=1 only in RESP.
- Request type:
  - `wr` and `rd` both 1: treated as write.
  - Neither set, with valid=1: no-op, still acknowledged with `rdata`=0.
- Read: `ita_o_rdata` is registered on the edge entering RESP, from the register value at that edge.
- Write: the target register updates on the clock edge that ends the RESP cycle.
- Prescaler: 16-bit counter `pcnt`, counts only while EN=1.
  - When `pcnt`==PRESC: `pcnt`←0 and mtime increments by 1. Otherwise `pcnt`+1.
  - PRESC=0 means mtime increments every cycle.
  - EN=0 holds both mtime and `pcnt`.
  - A write to PRESC clears `pcnt`.
- mtime is a full 64-bit increment: carry from LO into HI, and wraps 0xFFFF_FFFF_FFFF_FFFF → 0.
- A write to MTIME_LO/HI in the same cycle as an increment: the written half takes the written value, the other half keeps its pre-increment value (the write wins, and no increment or carry is applied that cycle).
- `ita_o_tmr_irq` = EN & (mtime ≥ mtimecmp), unsigned 64-bit compare, registered (one cycle behind the values).

## Timing
- Reset values:
  - `ita_o_ready`=0, `ita_o_rdata`=0, `ita_o_tmr_irq`=0, FSM=IDLE.
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESC=0, `pcnt`=0.
- Latency: valid first seen in IDLE in cycle 0 → `ita_o_ready`=1 in cycle 1+`WAIT_CYCLES`, for exactly one cycle.
- After RESP, at least one IDLE cycle follows. If valid is still high there, it is a new request (initiator must drop valid after ready).
- Changes to `ita_i_*` while in WAIT/RESP are ignored; the request is not re-sampled. Reads use the registered address captured at acceptance.
- Reset mid-transaction: FSM returns to IDLE immediately, any pending write is dropped, and `ita_o_ready` never pulses for that request.
- The timer keeps counting while transactions are in flight.

## Test plan
- Reset then read MTIMECMP_LO with `WAIT_CYCLES`=1 → ready in cycle 2, `rdata`=0xFFFF_FFFF; ready low otherwise.
- Write PRESC=3, CTRL=1, then wait 40 cycles and read MTIME_LO → value 10±1. Read MTIME_HI → 0.
- Write MTIME_LO=0xFFFF_FFFE, PRESC=0, EN=1, then read the HI word after several cycles → HI=1 (carry). Separately set mtime=all ones and confirm wrap to 0.
- Set MTIMECMP={0,20} and EN=1 with PRESC=0 → `irq` rises one cycle after mtime reaches 20. Write CTRL=0 → `irq` drops next cycle.
- Access to base+0x1C, and to an address outside the base: read returns 0, write changes no register, ready pulses once each. `wr`=`rd`=1 to MTIMECMP_LO=0x55 → register written.
- Assert `rst_n`=0 during WAIT of a write to CTRL → no ready pulse, CTRL=0 after reset. Repeat with `WAIT_CYCLES`=0 and 7 to confirm latency 1 and 8.

Source files
------------

// File: rtl/ita_timer_slv.sv
// ITA responder for a memory-mapped 64-bit machine timer (mtime/mtimecmp,
// prescaler, enable) with a programmable-wait-state request/response handshake.
module ita_timer_slv #(
  parameter int unsigned          PC_SIZE     = 32,
  parameter int unsigned          XLEN        = 32,
  parameter logic [PC_SIZE-1:0]   BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned          WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ita_i_valid,
  input  logic               ita_i_wr,
  input  logic               ita_i_rd,
  input  logic [PC_SIZE-1:0] ita_i_addr,
  input  logic [XLEN-1:0]    ita_i_wdata,
  output logic [XLEN-1:0]    ita_o_rdata,
  output logic               ita_o_ready,
  output logic               ita_o_tmr_irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;

  logic [2:0]  off_q;
  logic        hit_q, wr_q, rd_q;
  logic [31:0] wdata_q;

  logic [31:0] mtime_lo_q, mtime_lo_d, mtime_hi_q, mtime_hi_d;
  logic [31:0] cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
  logic        ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept, live_hit, sel_hit, sel_rd;
  logic [2:0]  sel_off;
  logic [31:0] rd_val;
  logic        wr_fire, we_lo, we_hi, we_clo, we_chi, we_ctrl, we_presc;
  logic        tick, lo_carry;
  logic [31:0] lo_inc, hi_inc;
  logic        unused_addr;

  assign unused_addr = ^ita_i_addr[1:0];
  assign accept      = (state_q == S_IDLE) && ita_i_valid;
  assign live_hit    = (ita_i_addr[PC_SIZE-1:5] == BASE_ADDR[PC_SIZE-1:5]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (ita_i_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_RESP;
        else              wcnt_d  = wcnt_q - 3'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge, so the read
  // must use the live request fields; otherwise the captured ones.
  always_comb begin
    sel_off = off_q;
    sel_hit = hit_q;
    sel_rd  = rd_q;
    if (state_q == S_IDLE) begin
      sel_off = ita_i_addr[4:2];
      sel_hit = live_hit;
      sel_rd  = ita_i_rd & ~ita_i_wr;
    end
    case (sel_off)
      3'd0:    rd_val = mtime_lo_q;
      3'd1:    rd_val = mtime_hi_q;
      3'd2:    rd_val = cmp_lo_q;
      3'd3:    rd_val = cmp_hi_q;
      3'd4:    rd_val = {31'd0, ctrl_q};
      3'd5:    rd_val = {16'd0, presc_q};
      default: rd_val = '0;
    endcase
    rdata_d = '0;
    if ((state_d == S_RESP) && sel_rd && sel_hit) rdata_d = rd_val;
  end

  assign wr_fire  = (state_q == S_RESP) && wr_q && hit_q;
  assign we_lo    = wr_fire && (off_q == 3'd0);
  assign we_hi    = wr_fire && (off_q == 3'd1);
  assign we_clo   = wr_fire && (off_q == 3'd2);
  assign we_chi   = wr_fire && (off_q == 3'd3);
  assign we_ctrl  = wr_fire && (off_q == 3'd4);
  assign we_presc = wr_fire && (off_q == 3'd5);

  assign tick               = ctrl_q && (pcnt_q == presc_q);
  assign {lo_carry, lo_inc} = {1'b0, mtime_lo_q} + 33'd1;
  assign hi_inc             = mtime_hi_q + {31'd0, lo_carry};

  always_comb begin
    pcnt_d = pcnt_q;
    if (we_presc)    pcnt_d = '0;
    else if (ctrl_q) pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;

    // A write to either mtime half suppresses that cycle's increment entirely.
    mtime_lo_d = mtime_lo_q;
    mtime_hi_d = mtime_hi_q;
    if (we_lo)       mtime_lo_d = wdata_q;
    else if (we_hi)  mtime_hi_d = wdata_q;
    else if (tick) begin
      mtime_lo_d = lo_inc;
      mtime_hi_d = hi_inc;
    end

    cmp_lo_d = we_clo   ? wdata_q        : cmp_lo_q;
    cmp_hi_d = we_chi   ? wdata_q        : cmp_hi_q;
    ctrl_d   = we_ctrl  ? wdata_q[0]     : ctrl_q;
    presc_d  = we_presc ? wdata_q[15:0]  : presc_q;
    irq_d    = ctrl_q && ({mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      off_q      <= '0;
      hit_q      <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      wdata_q    <= '0;
      mtime_lo_q <= '0;
      mtime_hi_q <= '0;
      cmp_lo_q   <= '1;
      cmp_hi_q   <= '1;
      ctrl_q     <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      if (accept) begin
        off_q   <= ita_i_addr[4:2];
        hit_q   <= live_hit;
        wr_q    <= ita_i_wr;
        rd_q    <= ita_i_rd & ~ita_i_wr;
        wdata_q <= ita_i_wdata[31:0];
      end
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      cmp_lo_q   <= cmp_lo_d;
      cmp_hi_q   <= cmp_hi_d;
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ita_o_ready   = (state_q == S_RESP);
  assign ita_o_rdata   = rdata_q;
  assign ita_o_tmr_irq = irq_q;

endmodule
